// File: rtl/iob_reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iob_reg_arb_pkg
// Brief    : Shared types and helpers for the iob_reg write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package iob_reg_arb_pkg;

  // Arbiter ownership state: free round-robin or held by a locking owner.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Widest register bank the decode helper can address (8-bit index).
  localparam int ONEHOT_MAX_W = 256;

  // Index to one-hot; callers size-cast the result down to their bank width.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot_decode(input logic [7:0] idx);
    logic [ONEHOT_MAX_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iob_rr_arbiter
// Brief    : Combinational N-way round-robin picker. Search starts at i_ptr
//            and wraps; returns one-hot grant and its index.
// Revision : 1.0 - initial release
// ============================================================================
module iob_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;
  logic             w_found;

  // Walk the requesters starting at the pointer; the first active one wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iob_reg_wr_arbiter
// Brief    : Round-robin arbiter sharing one iob_reg write bank among N_REQ
//            requesters, with a registered write stage and an optional lock
//            for back-to-back atomic writes (up to LOCK_MAX beats).
// Revision : 1.0 - initial release
// ============================================================================
module iob_reg_wr_arbiter
  import iob_reg_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int LOCK_MAX = 8
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ-1:0]          i_req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [(2**ADDR_W)-1:0]    o_reg_en,
  output logic [DATA_W-1:0]         o_reg_data_in,
  output logic                      o_reg_rst,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id,
  output logic                      o_locked
);

  localparam int N_REG = 2**ADDR_W;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX+1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [CNT_W-1:0] r_cnt;

  logic [N_REG-1:0]  r_reg_en;
  logic [DATA_W-1:0] r_reg_data;
  logic              r_reg_rst;
  logic [IDX_W-1:0]  r_grant_id;

  logic [N_REQ-1:0]  w_rr_grant;
  logic [IDX_W-1:0]  w_rr_idx;
  logic [N_REQ-1:0]  w_owner_oh;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [N_REG-1:0]  w_dec;
  logic [IDX_W-1:0]  w_ptr_next;
  logic              w_accept;

  iob_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx)
  );

  assign w_owner_oh = N_REQ'(1) << r_owner;
  assign w_sel_idx  = (r_state == LOCKED) ? r_owner : w_rr_idx;
  assign w_accept   = |o_req_ready;
  assign w_ptr_next = (w_sel_idx == IDX_W'(N_REQ-1)) ? '0 : w_sel_idx + 1'b1;
  assign w_dec      = N_REG'(onehot_decode(8'(w_sel_addr)));

  // Ready fan-out: rr winner when free, owner only when locked, nothing in reset.
  always_comb begin
    o_req_ready = '0;
    if (arst && !rst) begin
      if (r_state == IDLE) begin
        o_req_ready = w_rr_grant;
      end else if (i_req_valid[r_owner]) begin
        o_req_ready = w_owner_oh;
      end
    end
  end

  // Route the selected requester's address and data to the write stage.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel_idx == IDX_W'(i)) begin
        w_sel_addr = i_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = i_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ownership FSM, rr pointer and lock beat counter. r_cnt counts beats taken
  // in the current tenure; the beat that brings it to LOCK_MAX is the last one.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_ptr <= w_ptr_next;
      end
      case (r_state)
        IDLE: begin
          if (w_accept && i_req_lock[w_sel_idx] && (LOCK_MAX > 1)) begin
            r_state <= LOCKED;
            r_owner <= w_sel_idx;
            r_cnt   <= CNT_W'(1);
          end
        end
        LOCKED: begin
          if (w_accept) begin
            if (!i_req_lock[r_owner] || (r_cnt >= CNT_W'(LOCK_MAX-1))) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (!i_req_lock[r_owner]) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Write stage: one registered beat per cycle toward the bank; reg_rst is rst delayed.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_reg_en   <= '0;
      r_reg_data <= '0;
      r_reg_rst  <= 1'b0;
      r_grant_id <= '0;
    end else if (rst) begin
      r_reg_en   <= '0;
      r_reg_rst  <= 1'b1;
      r_grant_id <= '0;
    end else begin
      r_reg_rst <= 1'b0;
      r_reg_en  <= '0;
      if (w_accept) begin
        r_reg_en   <= w_dec;
        r_reg_data <= w_sel_data;
        r_grant_id <= w_sel_idx;
      end
    end
  end

  assign o_reg_en      = r_reg_en;
  assign o_reg_data_in = r_reg_data;
  assign o_reg_rst     = r_reg_rst;
  assign o_grant_id    = r_grant_id;
  assign o_locked      = (r_state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_iob_reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_reg_wr_arbiter
// Brief    : Directed bench for iob_reg_wr_arbiter with a behavioural model
//            compared every cycle plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_reg_wr_arbiter;

  localparam int NQ = 4;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int LM = 8;

  logic           clk;
  logic           arst;
  logic           rst;
  logic [NQ-1:0]  valid;
  logic [NQ-1:0]  lock;
  logic [AW-1:0]  addr [NQ];
  logic [DW-1:0]  data [NQ];
  logic [NQ*AW-1:0] addr_bus;
  logic [NQ*DW-1:0] data_bus;
  logic [NQ-1:0]  ready;
  logic [7:0]     reg_en;
  logic [DW-1:0]  reg_data_in;
  logic           reg_rst;
  logic [1:0]     grant_id;
  logic           locked;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      addr_bus[i*AW +: AW] = addr[i];
      data_bus[i*DW +: DW] = data[i];
    end
  end

  iob_reg_wr_arbiter #(
    .N_REQ(NQ), .DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(LM)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .rst          (rst),
    .i_req_valid  (valid),
    .i_req_lock   (lock),
    .i_req_addr   (addr_bus),
    .i_req_data   (data_bus),
    .o_req_ready  (ready),
    .o_reg_en     (reg_en),
    .o_reg_data_in(reg_data_in),
    .o_reg_rst    (reg_rst),
    .o_grant_id   (grant_id),
    .o_locked     (locked)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_ptr    = 0;
  bit         m_locked = 0;
  int         m_owner  = 0;
  int         m_beats  = 0;
  logic [7:0] m_en     = 0;
  logic [DW-1:0] m_data = 0;
  bit         m_rst    = 0;
  int         m_gid    = 0;

  function automatic logic [NQ-1:0] f_ready();
    if (!arst || rst) return '0;
    if (m_locked) return valid[m_owner] ? (NQ'(1) << m_owner) : '0;
    for (int k = 0; k < NQ; k++) begin
      int j;
      j = (m_ptr + k) % NQ;
      if (valid[j]) return NQ'(1) << j;
    end
    return '0;
  endfunction

  always @(posedge clk or negedge arst) begin
    logic [NQ-1:0] r;
    int w;
    if (!arst) begin
      m_ptr = 0; m_locked = 0; m_owner = 0; m_beats = 0;
      m_en = 0; m_data = 0; m_rst = 0; m_gid = 0;
    end else if (rst) begin
      m_ptr = 0; m_locked = 0; m_beats = 0; m_en = 0; m_rst = 1; m_gid = 0;
    end else begin
      r = f_ready();
      m_rst = 0;
      m_en  = 0;
      if (r != 0) begin
        w = 0;
        for (int i = 0; i < NQ; i++) if (r[i]) w = i;
        m_en   = 8'(1) << addr[w];
        m_data = data[w];
        m_gid  = w;
        m_ptr  = (w + 1) % NQ;
        if (!m_locked) begin
          if (lock[w]) begin m_locked = 1; m_owner = w; m_beats = 1; end
        end else begin
          m_beats++;
          if (!lock[w] || m_beats == LM) m_locked = 0;
        end
      end else if (m_locked && !lock[m_owner]) begin
        m_locked = 0;
      end
    end
  end

  // Register bank fed by the arbiter outputs (iob_reg behaviour).
  logic [DW-1:0] bank [8];
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else if (reg_rst) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) if (reg_en[i]) bank[i] <= reg_data_in;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ready",    64'(ready),       64'(f_ready()));
      chk("m_reg_en",   64'(reg_en),      64'(m_en));
      chk("m_reg_data", 64'(reg_data_in), 64'(m_data));
      chk("m_reg_rst",  64'(reg_rst),     64'(m_rst));
      chk("m_grant_id", 64'(grant_id),    64'(m_gid));
      chk("m_locked",   64'(locked),      64'(m_locked));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int n1;
    logic [NQ-1:0] other;
    logic [NQ-1:0] rcur;

    arst = 0; rst = 0; valid = '1; lock = '0;
    for (int i = 0; i < NQ; i++) begin
      addr[i] = AW'(i);
      data[i] = 32'h1000_0000 + 32'(i);
    end

    // Reset held for three cycles with every requester valid.
    step();
    cmp_en = 1;
    step();
    step();
    chk("rst_ready",  64'(ready),    64'h0);
    chk("rst_reg_en", 64'(reg_en),   64'h0);
    chk("rst_reg_rst",64'(reg_rst),  64'h0);
    chk("rst_gid",    64'(grant_id), 64'h0);
    arst = 1;

    // Round robin from pointer 0.
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 64'(ready), 64'(NQ'(1) << rr_exp[k]));
      if (k > 0) chk("rr_reg_en", 64'(reg_en), 64'(8'(1) << rr_exp[k-1]));
      step();
    end
    valid = '0;
    #1;
    chk("rr_last_en", 64'(reg_en), 64'h01);
    step();

    // Latency: req2 addr5.
    valid = 4'b0100; addr[2] = 3'd5; data[2] = 32'hA5A5_0001;
    #1;
    chk("lat_ready", 64'(ready), 64'h4);
    step();
    valid = '0;
    #1;
    chk("lat_reg_en",   64'(reg_en),      64'h20);
    chk("lat_reg_data", 64'(reg_data_in), 64'hA5A5_0001);
    step();
    chk("lat_bank", 64'(bank[5]), 64'hA5A5_0001);

    // Single req0 beat to place the pointer at 1.
    valid = 4'b0001;
    step();
    valid = '0;
    step();

    // Lock tenure: req1 wants 10 locked beats, req0 and req3 contend.
    valid = 4'b1011; lock = 4'b0010;
    n1 = 0; other = '0;
    for (int k = 0; k < 16; k++) begin
      #1;
      rcur = ready;
      if (rcur == 4'b0010) n1++;
      else begin other = rcur; break; end
      step();
    end
    chk("lock_beats", 64'(n1),    64'd8);
    chk("lock_next",  64'(other), 64'b1000);
    step();
    valid = '0; lock = '0;
    step();

    // Lock released by dropping lock with no valid.
    valid = 4'b0010; lock = 4'b0010;
    step();
    chk("rel_locked", 64'(locked), 64'h1);
    valid = 4'b0001; lock = 4'b0000;
    #1;
    chk("rel_ready0", 64'(ready), 64'h0);
    step();
    chk("rel_unlock", 64'(locked), 64'h0);
    chk("rel_ready1", 64'(ready),  64'h1);
    step();
    valid = '0;
    step();

    // rst while locked with a pending owner beat.
    valid = 4'b0100; lock = 4'b0100; addr[2] = 3'd6; data[2] = 32'h0BAD_F00D;
    step();
    rst = 1;
    #1;
    chk("srst_ready",  64'(ready),  64'h0);
    chk("srst_wr_en",  64'(reg_en), 64'h40);
    step();
    rst = 0; valid = '1; lock = '0;
    #1;
    chk("srst_reg_rst", 64'(reg_rst),  64'h1);
    chk("srst_reg_en",  64'(reg_en),   64'h0);
    chk("srst_locked",  64'(locked),   64'h0);
    chk("srst_gid",     64'(grant_id), 64'h0);
    chk("srst_ptr0",    64'(ready),    64'h1);
    step();
    valid = '0;
    step();
    step();
    cmp_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
